bcd_serial_accumulator: RTL and testbench

- Parametrised multi-digit BCD adder/accumulator. Processes one BCD digit per clock, least-significant digit first, with +6 decimal correction per digit.
- Holds the result in a display register that drives one 7-segment output per digit plus a carry digit.
- Next-generation block for the lab BCD display path: N digits instead of one, start/busy/done handshake, accumulate mode, and input-validity flagging.

---
 rtl/bcd_pkg.sv | 35 +++
 rtl/bcd_digit_add.sv | 31 +++
 rtl/bcd_serial_accumulator.sv | 152 +++++++++++++++
 tb/tb_bcd_serial_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD serial accumulator.
//   state_t    : controller states (IDLE, ADD, COMMIT)
//   BCD_MAX    : largest valid BCD digit
//   BCD_CORR   : decimal correction added when a digit sum exceeds BCD_MAX
//   SEG_BLANK  : all segments off (active-low)
//   SEG_ONE    : the numeral "1" (segments b and c lit)
//   seg_decode : 4-bit value to active-low {g,f,e,d,c,b,a}; values above 9 blank
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_CORR  = 4'd6;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ONE   = 7'h79;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] pat;
    case (v)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder with +6 decimal correction (combinational).
//   x, y : operand digits
//   ci   : carry in
//   s    : corrected sum digit
//   co   : decimal carry out
//   bad  : an operand digit is above 9
module bcd_digit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);
  import bcd_pkg::*;

  logic [4:0] raw;

  always_comb begin
    raw = {1'b0, x} + {1'b0, y} + {4'b0, ci};
    if (raw > {1'b0, BCD_MAX}) begin
      s  = raw[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = raw[3:0];
      co = 1'b0;
    end
    bad = (x > BCD_MAX) || (y > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// Multi-digit BCD adder/accumulator, one digit per clock, LSD first.
// Result is held in a display register driving one 7-segment per digit
// plus a carry digit.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   start, load  : begin operation / copy a into acc (IDLE only; start wins)
//   mode         : 0 = a + b + cin, 1 = acc + a + cin
//   sub          : subtract request (only with BCD_SUB_EN defined)
//   a, b, cin    : operands, digit 0 in bits [3:0]
//   busy, done   : in progress / one-cycle commit pulse
//   acc, cout    : committed result and top-digit carry
//   err          : sticky, an operand digit was above 9
//   seg, seg_c   : active-low segments per digit, carry digit ("1" or blank)
// Optional feature macro: BCD_SUB_EN (9's-complement subtraction).
module bcd_serial_accumulator #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                load,
  input  logic                mode,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] acc,
  output logic                cout,
  output logic                err,
  output logic [7*DIGITS-1:0] seg,
  output logic [6:0]          seg_c
);
  import bcd_pkg::*;

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    x_q, y_q, work_q, acc_q;
  logic            carry_q, cout_q, err_q, done_q;
  logic [W-1:0]    x_sel, y_sel;
  logic            ci_sel;
  logic [3:0]      dsum;
  logic            dco, dbad;
  logic            last;

`ifndef BCD_SUB_EN
  logic unused_sub;
  assign unused_sub = sub;
`endif

  // Operand selection happens once at start; the latched copies are then
  // shifted right so the adder always sees the current digit in bits [3:0].
  always_comb begin
    x_sel  = mode ? acc_q : a;
    y_sel  = mode ? a : b;
    ci_sel = cin;
`ifdef BCD_SUB_EN
    // 9 - d maps any digit above 9 to 10..15, so err still flags it.
    if (sub) begin
      for (int unsigned i = 0; i < DIGITS; i++)
        y_sel[4*i +: 4] = BCD_MAX - y_sel[4*i +: 4];
      ci_sel = 1'b1;
    end
`endif
  end

  bcd_digit_add u_digit (
    .x   (x_q[3:0]),
    .y   (y_q[3:0]),
    .ci  (carry_q),
    .s   (dsum),
    .co  (dco),
    .bad (dbad)
  );

  assign last = (idx_q == IW'(DIGITS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      work_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= x_sel;
            y_q     <= y_sel;
            carry_q <= ci_sel;
            err_q   <= 1'b0;
            idx_q   <= '0;
          end else if (load) begin
            acc_q  <= a;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        ADD: begin
          // New digit enters at the top; after DIGITS shifts digit 0 is at [3:0].
          work_q  <= W'({dsum, work_q} >> 4);
          x_q     <= x_q >> 4;
          y_q     <= y_q >> 4;
          carry_q <= dco;
          err_q   <= err_q | dbad;
          idx_q   <= idx_q + 1'b1;
        end
        COMMIT: begin
          acc_q  <= work_q;
          cout_q <= carry_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    seg = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      seg[7*i +: 7] = seg_decode(acc_q[4*i +: 4]);
  end

  assign seg_c = cout_q ? SEG_ONE : SEG_BLANK;
  assign busy  = (state_q == ADD) || (state_q == COMMIT);
  assign done  = done_q;
  assign acc   = acc_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
module tb_bcd_serial_accumulator;

  logic        clock = 1'b0;
  logic        reset, start, load, mode, sub, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, err;
  logic [15:0] acc;
  logic [27:0] seg;
  logic [6:0]  seg_c;

  int compared   = 0;
  int mismatched = 0;
  int lat, bcnt, dcnt;

  bcd_serial_accumulator #(.DIGITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .load  (load),
    .mode  (mode),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .acc   (acc),
    .cout  (cout),
    .err   (err),
    .seg   (seg),
    .seg_c (seg_c)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits for done with a cycle budget; lat counts edges after the start edge.
  task automatic wait_done();
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  // Start an operation, then scramble the inputs to prove they were latched.
  task automatic run_op(input logic m, input logic s, input logic [15:0] aa,
                        input logic [15:0] bb, input logic c);
    mode = m; sub = s; a = aa; b = bb; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h7777; b = 16'h8888; cin = ~c; mode = ~m; sub = ~s;
    wait_done();
  endtask

  task automatic do_load(input logic [15:0] aa);
    a = aa; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; load = 1'b0; mode = 1'b0; sub = 1'b0;
    cin = 1'b0; a = '0; b = '0;
    #12;
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_acc",   {16'b0, acc}, 32'h0);
    check("rst_cout",  {31'b0, cout}, 32'd0);
    check("rst_err",   {31'b0, err}, 32'd0);
    check("rst_seg",   {4'b0, seg}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
    check("rst_seg_c", {25'b0, seg_c}, 32'h7F);
    reset = 1'b1;
    tick();

    // Basic add: 1234 + 5678 = 6912
    run_op(1'b0, 1'b0, 16'h1234, 16'h5678, 1'b0);
    check("add_latency", lat, 32'd5);
    check("add_busy_cycles", bcnt, 32'd5);
    check("add_acc",  {16'b0, acc}, 32'h6912);
    check("add_cout", {31'b0, cout}, 32'd0);
    check("add_err",  {31'b0, err}, 32'd0);
    check("add_seg0", {25'b0, seg[6:0]}, 32'h24);
    check("add_seg",  {4'b0, seg}, {4'b0, 7'h02, 7'h10, 7'h79, 7'h24});
    check("add_seg_c", {25'b0, seg_c}, 32'h7F);
    tick();
    check("done_one_cycle", {31'b0, done}, 32'd0);

    // Carry out: 9999 + 0001 = 1_0000; start in the cycle after done
    run_op(1'b0, 1'b0, 16'h9999, 16'h0001, 1'b0);
    check("b2b_latency", lat, 32'd5);
    check("cy_acc",   {16'b0, acc}, 32'h0000);
    check("cy_cout",  {31'b0, cout}, 32'd1);
    check("cy_seg_c", {25'b0, seg_c}, 32'h79);

    // Accumulate: load 0500, then 0500 + 0500 + 1 = 1001
    tick();
    do_load(16'h0500);
    check("load_acc",  {16'b0, acc}, 32'h0500);
    check("load_cout", {31'b0, cout}, 32'd0);
    run_op(1'b1, 1'b0, 16'h0500, 16'h0000, 1'b1);
    check("accum_acc",  {16'b0, acc}, 32'h1001);
    check("accum_cout", {31'b0, cout}, 32'd0);

    // Invalid digit: 00A0 + 0000 -> err, corrected result 0100
    tick();
    run_op(1'b0, 1'b0, 16'h00A0, 16'h0000, 1'b0);
    check("inv_err",  {31'b0, err}, 32'd1);
    check("inv_acc",  {16'b0, acc}, 32'h0100);
    check("inv_cout", {31'b0, cout}, 32'd0);
    tick();
    check("inv_err_sticky", {31'b0, err}, 32'd1);
    do_load(16'h1111);
    check("inv_err_cleared", {31'b0, err}, 32'd0);
    check("inv_load_acc", {16'b0, acc}, 32'h1111);

    // start held during busy is ignored; inputs changed mid-operation
    mode = 1'b0; sub = 1'b0; a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h9999; b = 16'h9999;
    repeat (3) tick();
    check("acc_stable_busy", {16'b0, acc}, 32'h1111);
    start = 1'b0;
    dcnt = 0;
    repeat (12) begin
      tick();
      if (done) dcnt++;
    end
    check("one_done", dcnt, 32'd1);
    check("ignore_acc", {16'b0, acc}, 32'h0003);
    check("ignore_idle", {31'b0, busy}, 32'd0);

    // Reset during the third ADD cycle
    mode = 1'b0; a = 16'h0011; b = 16'h0022; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_acc",  {16'b0, acc}, 32'h0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_seg",  {4'b0, seg}, {4'b0, 7'h40, 7'h40, 7'h40, 7'h40});
    #2;
    reset = 1'b1;
    dcnt = 0;
    repeat (8) begin
      tick();
      if (done || busy) dcnt++;
    end
    check("mid_no_done", dcnt, 32'd0);
    check("mid_acc_zero", {16'b0, acc}, 32'h0);

    // start and load together: start wins, acc not loaded
    mode = 1'b0; sub = 1'b0; a = 16'h0002; b = 16'h0003; cin = 1'b0;
    start = 1'b1; load = 1'b1;
    tick();
    start = 1'b0; load = 1'b0;
    check("sl_no_load", {16'b0, acc}, 32'h0);
    check("sl_busy", {31'b0, busy}, 32'd1);
    wait_done();
    check("sl_acc", {16'b0, acc}, 32'h0005);

    tick();
`ifdef BCD_SUB_EN
    run_op(1'b0, 1'b1, 16'h0100, 16'h0001, 1'b0);
    check("sub_acc",  {16'b0, acc}, 32'h0099);
    check("sub_cout", {31'b0, cout}, 32'd1);
    tick();
    run_op(1'b0, 1'b1, 16'h0001, 16'h0100, 1'b0);
    check("subneg_acc",  {16'b0, acc}, 32'h9901);
    check("subneg_cout", {31'b0, cout}, 32'd0);
`else
    run_op(1'b0, 1'b1, 16'h0100, 16'h0001, 1'b0);
    check("sub_ignored_acc",  {16'b0, acc}, 32'h0101);
    check("sub_ignored_cout", {31'b0, cout}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
